// File: rtl/bus_memory_responder.sv
// 8088 minimum-mode bus slave: a byte array behind one chip select, with optional RDY wait states.
// Read data appears WAIT_STATES+1 edges after RD is sampled low. RDY stalls the master; the responder never backs off.
module bus_memory_responder #(
  parameter int ADDR_BITS   = 12,
  parameter int WAIT_STATES = 0,
  parameter int IO_SPACE    = 0
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        ALE,
  input  logic        IOM,
  input  logic        CS,
  input  logic        RD,
  input  logic        WR,
  input  logic [19:0] Address,
  inout  wire  [7:0]  Data,
  output logic        RDY
);

  typedef enum logic [2:0] {IDLE, ADDR, RWAIT, RDRIVE, WWAIT, WDONE} state_t;

  localparam logic [3:0] WS  = WAIT_STATES[3:0];
  localparam logic       IOS = IO_SPACE[0];

  state_t                 state;
  logic [3:0]             cnt;
  logic [7:0]             rdata;
  logic [ADDR_BITS-1:0]   idx;
  logic                   rdy_q;
  logic [7:0]             mem [0:(1<<ADDR_BITS)-1];
  logic                   hit;
  logic                   mem_we;
  logic                   unused_addr_hi;

  // Upper address bits belong to the external chip-select decode.
  assign unused_addr_hi = ^Address[19:ADDR_BITS];

  assign hit    = ALE & CS & (IOM == IOS);
  assign mem_we = !RESET && !hit &&
                  ((state == ADDR  && !WR && RD && WS == 4'd0) ||
                   (state == WWAIT && !WR && cnt == WS));

  always_ff @(posedge CLK) begin
    if (mem_we)
      mem[idx] <= Data;
  end

  // A fresh address phase for this device overrides whatever cycle was in flight.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      cnt   <= '0;
      rdata <= '0;
      idx   <= '0;
      rdy_q <= 1'b1;
    end else if (hit) begin
      state <= ADDR;
      idx   <= Address[ADDR_BITS-1:0];
      cnt   <= '0;
      rdy_q <= 1'b1;
    end else begin
      case (state)
        ADDR: begin
          if (!RD && WR) begin
            rdata <= mem[idx];
            if (WS == 4'd0) begin
              state <= RDRIVE;
            end else begin
              state <= RWAIT;
              cnt   <= 4'd1;
              rdy_q <= 1'b0;
            end
          end else if (!WR && RD) begin
            if (WS == 4'd0) begin
              state <= WDONE;
            end else begin
              state <= WWAIT;
              cnt   <= 4'd1;
              rdy_q <= 1'b0;
            end
          end
        end
        RWAIT: begin
          if (RD) begin
            state <= IDLE;
            rdy_q <= 1'b1;
          end else if (cnt == WS) begin
            state <= RDRIVE;
            rdy_q <= 1'b1;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        RDRIVE: if (RD) state <= IDLE;
        WWAIT: begin
          if (WR) begin
            state <= IDLE;
            rdy_q <= 1'b1;
          end else if (cnt == WS) begin
            state <= WDONE;
            rdy_q <= 1'b1;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        WDONE: if (WR) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign RDY  = rdy_q;
  // WR gating keeps us off the bus even if the master misbehaves mid-read.
  assign Data = (state == RDRIVE && WR) ? rdata : 8'hzz;

endmodule

// File: tb/tb_bus_memory_responder.sv
// Scoreboard bench for bus_memory_responder with three instances (0, 2 and 3 wait states).
module tb_bus_memory_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, ale, iom, rd, wr;
  logic [2:0]  cs, drv;
  logic [19:0] addr;
  logic [7:0]  tb_dat;
  tri1  [7:0]  d0, d1, d2;
  wire  [2:0]  rdy;

  assign d0 = drv[0] ? tb_dat : 8'hzz;
  assign d1 = drv[1] ? tb_dat : 8'hzz;
  assign d2 = drv[2] ? tb_dat : 8'hzz;

  bus_memory_responder #(.ADDR_BITS(12), .WAIT_STATES(0), .IO_SPACE(0)) u_ws0 (
    .CLK(clk), .RESET(rst), .ALE(ale), .IOM(iom), .CS(cs[0]), .RD(rd), .WR(wr),
    .Address(addr), .Data(d0), .RDY(rdy[0]));
  bus_memory_responder #(.ADDR_BITS(12), .WAIT_STATES(2), .IO_SPACE(0)) u_ws2 (
    .CLK(clk), .RESET(rst), .ALE(ale), .IOM(iom), .CS(cs[1]), .RD(rd), .WR(wr),
    .Address(addr), .Data(d1), .RDY(rdy[1]));
  bus_memory_responder #(.ADDR_BITS(12), .WAIT_STATES(3), .IO_SPACE(1)) u_ws3 (
    .CLK(clk), .RESET(rst), .ALE(ale), .IOM(iom), .CS(cs[2]), .RD(rd), .WR(wr),
    .Address(addr), .Data(d2), .RDY(rdy[2]));

  typedef struct {
    string      nm;
    int         k;
    bit         cd;
    logic [7:0] d;
    logic       r;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic logic [7:0] bus(int k);
    case (k)
      0:       return d0;
      1:       return d1;
      default: return d2;
    endcase
  endfunction

  // Undriven bus reads 8'hFF through the pull-up, so stored test bytes avoid FF.
  always @(negedge clk) begin : monitor
    exp_t       e;
    logic       gr;
    logic [7:0] gd;
    while (sb.size() > 0) begin
      e  = sb.pop_front();
      gr = rdy[e.k];
      gd = bus(e.k);
      checks++;
      if (gr !== e.r) begin
        errors++;
        $display("FAIL %s dut%0d rdy: got %b want %b", e.nm, e.k, gr, e.r);
      end
      if (e.cd) begin
        checks++;
        if (gd !== e.d) begin
          errors++;
          $display("FAIL %s dut%0d data: got %h want %h", e.nm, e.k, gd, e.d);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic want(string nm, int k, bit cd, logic [7:0] d, logic r);
    exp_t e;
    e.nm = nm; e.k = k; e.cd = cd; e.d = d; e.r = r;
    sb.push_back(e);
  endtask

  task automatic addr_ph(int k, logic [19:0] a, logic io);
    ale = 1'b1; cs = '0; cs[k] = 1'b1; iom = io; addr = a;
    rd = 1'b1; wr = 1'b1; drv = '0;
    want("addr", k, 1'b1, 8'hFF, 1'b1);
    tick();
    ale = 1'b0;
  endtask

  task automatic wr_cyc(int k, logic [19:0] a, logic io, logic [7:0] v, int ws);
    addr_ph(k, a, io);
    wr = 1'b0; tb_dat = v; drv[k] = 1'b1;
    for (int i = 0; i < ws; i++) begin
      want("wwait", k, 1'b0, 8'h00, 1'b0);
      tick();
    end
    want("wdone", k, 1'b0, 8'h00, 1'b1);
    tick();
    wr = 1'b1; drv = '0;
    want("wend", k, 1'b1, 8'hFF, 1'b1);
    tick();
    cs = '0;
  endtask

  task automatic rd_cyc(int k, logic [19:0] a, logic io, logic [7:0] v, int ws);
    addr_ph(k, a, io);
    rd = 1'b0;
    for (int i = 0; i < ws; i++) begin
      want("rwait", k, 1'b1, 8'hFF, 1'b0);
      tick();
    end
    want("rdata", k, 1'b1, v, 1'b1);
    tick();
    want("rhold", k, 1'b1, v, 1'b1);
    tick();
    rd = 1'b1;
    want("rrel", k, 1'b1, 8'hFF, 1'b1);
    tick();
    cs = '0;
  endtask

  initial begin
    rst = 1'b1; ale = 1'b0; iom = 1'b0; rd = 1'b1; wr = 1'b1;
    cs = '0; drv = '0; addr = '0; tb_dat = '0;
    for (int k = 0; k < 3; k++) want("reset", k, 1'b1, 8'hFF, 1'b1);
    tick();
    tick();
    rst = 1'b0;

    // Zero wait states: basic write/read plus high-address aliasing.
    wr_cyc(0, 20'h00123, 1'b0, 8'hA5, 0);
    rd_cyc(0, 20'h00123, 1'b0, 8'hA5, 0);
    rd_cyc(0, 20'hFE123, 1'b0, 8'hA5, 0);

    // Two wait states.
    wr_cyc(1, 20'h00456, 1'b0, 8'h3C, 2);
    rd_cyc(1, 20'h00456, 1'b0, 8'h3C, 2);

    // Reset held through a driven read; contents survive.
    wr_cyc(0, 20'h00200, 1'b0, 8'h5A, 0);
    addr_ph(0, 20'h00200, 1'b0);
    rd = 1'b0;
    want("pre_rst", 0, 1'b1, 8'h5A, 1'b1);
    tick();
    rst = 1'b1;
    want("rst1", 0, 1'b1, 8'hFF, 1'b1);
    tick();
    want("rst2", 0, 1'b1, 8'hFF, 1'b1);
    tick();
    rst = 1'b0; rd = 1'b1; cs = '0;
    want("post_rst", 0, 1'b1, 8'hFF, 1'b1);
    tick();
    rd_cyc(0, 20'h00200, 1'b0, 8'h5A, 0);

    // Chip select low at ALE: ignore read and write.
    ale = 1'b1; cs = '0; iom = 1'b0; addr = 20'h00123;
    want("nocs_a", 0, 1'b1, 8'hFF, 1'b1);
    tick();
    ale = 1'b0; rd = 1'b0;
    for (int i = 0; i < 3; i++) begin
      want("nocs_rd", 0, 1'b1, 8'hFF, 1'b1);
      tick();
    end
    rd = 1'b1; ale = 1'b1;
    tick();
    ale = 1'b0; wr = 1'b0; tb_dat = 8'h77; drv[0] = 1'b1;
    tick();
    tick();
    wr = 1'b1; drv = '0;
    tick();
    rd_cyc(0, 20'h00123, 1'b0, 8'hA5, 0);

    // IOM mismatch on both address spaces.
    for (int j = 0; j < 2; j++) begin
      int k;
      k = (j == 0) ? 0 : 2;
      ale = 1'b1; cs = '0; cs[k] = 1'b1; iom = (k == 0); addr = 20'h00050;
      want("iom_a", k, 1'b1, 8'hFF, 1'b1);
      tick();
      ale = 1'b0; rd = 1'b0;
      for (int i = 0; i < 5; i++) begin
        want("iom_rd", k, 1'b1, 8'hFF, 1'b1);
        tick();
      end
      rd = 1'b1; cs = '0;
      tick();
    end

    // Three wait states, IO space; write aborted in WWAIT at cnt=1.
    wr_cyc(2, 20'h00050, 1'b1, 8'h11, 3);
    addr_ph(2, 20'h00050, 1'b1);
    wr = 1'b0; tb_dat = 8'h99; drv[2] = 1'b1;
    want("ww_c1", 2, 1'b0, 8'h00, 1'b0);
    tick();
    wr = 1'b1; drv = '0;
    want("ww_abort", 2, 1'b1, 8'hFF, 1'b1);
    tick();
    cs = '0;
    tick();
    rd_cyc(2, 20'h00050, 1'b1, 8'h11, 3);

    // New address phase while in WDONE restarts with the new index.
    wr_cyc(0, 20'h00300, 1'b0, 8'h42, 0);
    addr_ph(0, 20'h00301, 1'b0);
    wr = 1'b0; tb_dat = 8'h66; drv[0] = 1'b1;
    want("wd", 0, 1'b0, 8'h00, 1'b1);
    tick();
    ale = 1'b1; addr = 20'h00300; wr = 1'b1; drv = '0;
    want("abort_addr", 0, 1'b1, 8'hFF, 1'b1);
    tick();
    ale = 1'b0; rd = 1'b0;
    want("abort_rd", 0, 1'b1, 8'h42, 1'b1);
    tick();
    rd = 1'b1;
    want("abort_rel", 0, 1'b1, 8'hFF, 1'b1);
    tick();
    cs = '0;
    rd_cyc(0, 20'h00301, 1'b0, 8'h66, 0);

    tick();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
